// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with two-word blocks and a critical-path-free hit.
// A miss latches its block address and fills word0 then word1 from the memory controller.
module icache_fill #(
  parameter int SETS = 8,
  parameter int BLKW = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - 3 - IW;

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1} state_t;

  state_t          state, next;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tags [SETS];
  logic [31:0]     data [SETS][BLKW];
  logic [TW-1:0]   miss_tag;
  logic [IW-1:0]   miss_idx;

  logic [TW-1:0]   req_tag;
  logic [IW-1:0]   req_idx;
  logic            req_off;
  logic            lookup;
  logic            unused_ok;

  assign req_tag   = imemaddr[31:IW+3];
  assign req_idx   = imemaddr[IW+2:3];
  assign req_off   = imemaddr[2];
  assign unused_ok = &{1'b0, imemaddr[1:0]};
  assign lookup    = valid[req_idx] && (tags[req_idx] == req_tag);

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (imemREN && !lookup && !flush) next = FETCH0;
      FETCH0:  if (!iwait) next = FETCH1;
      FETCH1:  if (!iwait) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (!RST) begin
      case (state)
        IDLE: begin
          ihit = imemREN && lookup && !flush;
          if (ihit) imemload = data[req_idx][req_off];
        end
        FETCH0: begin
          iREN  = 1'b1;
          iaddr = {miss_tag, miss_idx, 3'b000};
        end
        FETCH1: begin
          iREN  = 1'b1;
          iaddr = {miss_tag, miss_idx, 3'b100};
        end
        default: ;
      endcase
    end
  end

  // Valid is dropped when the fill starts so a half-written frame can never hit;
  // flush/reset take priority over any capture on the same edge.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (next == FETCH0) begin
            valid[req_idx] <= 1'b0;
            miss_tag       <= req_tag;
            miss_idx       <= req_idx;
          end
        end
        FETCH0: begin
          if (!iwait) data[miss_idx][1'b0] <= iload;
        end
        FETCH1: begin
          if (!iwait) begin
            data[miss_idx][1'b1] <= iload;
            tags[miss_idx]       <= miss_tag;
            valid[miss_idx]      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill.sv
// Directed bench for icache_fill: a per-cycle vector table plus a hand-written stalled fill.
module tb_icache_fill;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        flush = 1'b0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b0;
  logic [31:0] iload = '0;

  int tests = 0;
  int failed = 0;

  icache_fill #(.SETS(8), .BLKW(2)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        ren;
    logic [31:0] addr;
    logic        fl;
    logic        w;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst, input logic ren, input logic [31:0] addr,
                             input logic fl, input logic w, input logic [31:0] ld,
                             input logic eh, input logic [31:0] el,
                             input logic er, input logic [31:0] ea);
    vec_t r;
    r.rst = rst; r.ren = ren; r.addr = addr; r.fl = fl; r.w = w; r.ld = ld;
    r.e_hit = eh; r.e_load = el; r.e_ren = er; r.e_iaddr = ea;
    return r;
  endfunction

  task automatic check(input string nm, input logic eh, input logic [31:0] el,
                       input logic er, input logic [31:0] ea);
    tests++;
    if (ihit !== eh || imemload !== el || iREN !== er || iaddr !== ea) begin
      failed++;
      $display("FAIL %s: got hit=%0b load=%h ren=%0b iaddr=%h, expected hit=%0b load=%h ren=%0b iaddr=%h",
               nm, ihit, imemload, iREN, iaddr, eh, el, er, ea);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // cold miss and hits on both words
    vecs.push_back(v(1, 1, 32'h44,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 1, 32'h44,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 1, 32'h44,  0, 0, 32'hAAAA0001, 0, 32'h0,        1, 32'h40));
    vecs.push_back(v(0, 1, 32'h44,  0, 0, 32'hAAAA0002, 0, 32'h0,        1, 32'h44));
    vecs.push_back(v(0, 1, 32'h44,  0, 0, 32'h0,        1, 32'hAAAA0002, 0, 32'h0));
    vecs.push_back(v(0, 1, 32'h40,  0, 0, 32'h0,        1, 32'hAAAA0001, 0, 32'h0));
    vecs.push_back(v(0, 0, 32'h40,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    // conflict on index 0; request changes mid-fill must not disturb it
    vecs.push_back(v(0, 1, 32'h240, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 0, 32'h40,  0, 0, 32'hBBBB0001, 0, 32'h0,        1, 32'h240));
    vecs.push_back(v(0, 1, 32'h44,  0, 0, 32'hBBBB0002, 0, 32'h0,        1, 32'h244));
    vecs.push_back(v(0, 1, 32'h244, 0, 0, 32'h0,        1, 32'hBBBB0002, 0, 32'h0));
    vecs.push_back(v(0, 1, 32'h40,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 1, 32'h40,  0, 0, 32'hAAAA0001, 0, 32'h0,        1, 32'h40));
    vecs.push_back(v(0, 1, 32'h40,  0, 0, 32'hAAAA0002, 0, 32'h0,        1, 32'h44));
    vecs.push_back(v(0, 1, 32'h40,  0, 0, 32'h0,        1, 32'hAAAA0001, 0, 32'h0));
    // fill index 1 while requesting a valid block in index 0: no hit during fill
    vecs.push_back(v(0, 1, 32'h48,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 1, 32'h40,  0, 0, 32'hCCCC0001, 0, 32'h0,        1, 32'h48));
    vecs.push_back(v(0, 1, 32'h40,  0, 0, 32'hCCCC0002, 0, 32'h0,        1, 32'h4C));
    vecs.push_back(v(0, 1, 32'h4C,  0, 0, 32'h0,        1, 32'hCCCC0002, 0, 32'h0));
    // flush on the FETCH1 capture edge
    vecs.push_back(v(0, 1, 32'h240, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 1, 32'h240, 0, 0, 32'hDDDD0001, 0, 32'h0,        1, 32'h240));
    vecs.push_back(v(0, 1, 32'h240, 1, 0, 32'hDDDD0002, 0, 32'h0,        1, 32'h244));
    vecs.push_back(v(0, 1, 32'h240, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 1, 32'h240, 0, 0, 32'hEEEE0001, 0, 32'h0,        1, 32'h240));
    vecs.push_back(v(0, 1, 32'h240, 0, 0, 32'hEEEE0002, 0, 32'h0,        1, 32'h244));
    vecs.push_back(v(0, 1, 32'h240, 0, 0, 32'h0,        1, 32'hEEEE0001, 0, 32'h0));
    // flush in IDLE blocks a hit and the miss, then invalidates
    vecs.push_back(v(0, 1, 32'h240, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 1, 32'h240, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    // reset during FETCH0
    vecs.push_back(v(1, 1, 32'h240, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 0, 32'h240, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 1, 32'h4C,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 1, 32'h4C,  0, 0, 32'h12340001, 0, 32'h0,        1, 32'h48));
    vecs.push_back(v(0, 1, 32'h4C,  0, 0, 32'h12340002, 0, 32'h0,        1, 32'h4C));
    vecs.push_back(v(0, 1, 32'h4C,  0, 0, 32'h0,        1, 32'h12340002, 0, 32'h0));
    vecs.push_back(v(0, 1, 32'h48,  0, 0, 32'h0,        1, 32'h12340001, 0, 32'h0));
    vecs.push_back(v(0, 1, 32'h240, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(1, 1, 32'h240, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 1, 32'h4C,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 0, 32'h4C,  0, 1, 32'h0BAD0001, 0, 32'h0,        1, 32'h48));
    vecs.push_back(v(1, 0, 32'h4C,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(v(0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,        0, 32'h0));

    foreach (vecs[i]) begin
      @(negedge CLK);
      RST = vecs[i].rst; imemREN = vecs[i].ren; imemaddr = vecs[i].addr;
      flush = vecs[i].fl; iwait = vecs[i].w; iload = vecs[i].ld;
      #1 check($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_load, vecs[i].e_ren, vecs[i].e_iaddr);
    end

    // stalled fill of index 7: 4 wait cycles in FETCH0, 2 in FETCH1
    @(negedge CLK);
    RST = 1'b0; imemREN = 1'b1; imemaddr = 32'h7C; flush = 1'b0; iwait = 1'b0; iload = '0;
    #1 check("stall_miss", 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      iwait = 1'b1; iload = 32'hDEAD0000 + i;
      #1 check($sformatf("stall_f0_%0d", i), 0, 32'h0, 1, 32'h78);
    end
    @(negedge CLK);
    iwait = 1'b0; iload = 32'h5555AAAA;
    #1 check("stall_f0_cap", 0, 32'h0, 1, 32'h78);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      iwait = 1'b1; iload = 32'hBEEF0000 + i;
      #1 check($sformatf("stall_f1_%0d", i), 0, 32'h0, 1, 32'h7C);
    end
    @(negedge CLK);
    iwait = 1'b0; iload = 32'h66669999;
    #1 check("stall_f1_cap", 0, 32'h0, 1, 32'h7C);
    @(negedge CLK);
    iload = '0;
    #1 check("stall_hit_w1", 1, 32'h66669999, 0, 32'h0);
    @(negedge CLK);
    imemaddr = 32'h78;
    #1 check("stall_hit_w0", 1, 32'h5555AAAA, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
